// File: rtl/tap_stream_pkg.sv
// Shared types and elaboration-time helpers for the tap history streamer.
package tap_stream_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic int ncyc(input int depth, input int fold);
    return (fold != 0) ? (depth + 1) / 2 : depth;
  endfunction

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/tap_ring_buf.sv
// DEPTH-entry sample ring with an internal write pointer and two
// asynchronous read ports addressed as an offset back from the newest sample.
module tap_ring_buf
  import tap_stream_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 119,
  localparam int PW    = clog2_min1(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [PW-1:0]     i_off_a,
  input  logic [PW-1:0]     i_off_b,
  output logic [DATA_W-1:0] o_rd_a,
  output logic [DATA_W-1:0] o_rd_b
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     w_newest;
  logic [PW-1:0]     w_addr_a;
  logic [PW-1:0]     w_addr_b;

  // Modulo subtraction without a divider: wrap by adding DEPTH once.
  function automatic logic [PW-1:0] back_addr(input logic [PW-1:0] newest,
                                               input logic [PW-1:0] off);
    logic [PW:0] sum;
    sum = {1'b0, newest} - {1'b0, off};
    if (newest < off) sum = sum + (PW+1)'(DEPTH);
    return sum[PW-1:0];
  endfunction

  assign w_newest = (r_wr_ptr == '0) ? PW'(DEPTH - 1) : r_wr_ptr - PW'(1);
  assign w_addr_a = back_addr(w_newest, i_off_a);
  assign w_addr_b = back_addr(w_newest, i_off_b);
  assign o_rd_a   = r_mem[w_addr_a];
  assign o_rd_b   = r_mem[w_addr_b];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
      r_wr_ptr        <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/tap_stream_ctrl.sv
// Streams the last DEPTH samples, one tap (or symmetric pair) per enabled
// cycle, for each accepted input sample.
module tap_stream_ctrl
  import tap_stream_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 119,
  parameter int FOLD   = 0,
  localparam int NCYC  = ncyc(DEPTH, FOLD),
  localparam int IW    = clog2_min1(NCYC),
  localparam int PW    = clog2_min1(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     tap_valid,
  output logic [IW-1:0]            tap_idx,
  output logic signed [DATA_W-1:0] tap_a,
  output logic signed [DATA_W-1:0] tap_b,
  output logic                     frame_start,
  output logic                     frame_last,
  output logic                     busy
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NCYC - 1);
  localparam bit            ODD_FOLD = (FOLD != 0) && ((DEPTH % 2) == 1);

  state_t                   r_state;
  logic                     r_in_ready;
  logic                     r_tap_valid;
  logic                     r_start;
  logic                     r_last;
  logic                     r_busy;
  logic [IW-1:0]            r_idx;
  logic signed [DATA_W-1:0] r_a;
  logic signed [DATA_W-1:0] r_b;

  logic                     w_accept;
  logic [IW-1:0]            w_next_idx;
  logic [PW-1:0]            w_idx_ext;
  logic [PW-1:0]            w_off_a;
  logic [PW-1:0]            w_off_b;
  logic [DATA_W-1:0]        w_rd_a;
  logic [DATA_W-1:0]        w_rd_b;
  logic [DATA_W-1:0]        w_b_first;
  logic [DATA_W-1:0]        w_b_stream;

  assign w_accept   = in_valid & r_in_ready & clk_enable;
  assign w_next_idx = r_idx + IW'(1);
  assign w_idx_ext  = PW'(r_idx);

  // Reads happen one cycle ahead of the registered tap; on an accept edge
  // the new sample is not yet in the ring, so port b looks one slot nearer.
  assign w_off_a = w_idx_ext + PW'(1);
  assign w_off_b = PW'(DEPTH - 2) - (w_accept ? '0 : w_idx_ext);

  assign w_b_first  = (FOLD == 0) ? '0 : w_rd_b;
  assign w_b_stream = ((FOLD == 0) || (ODD_FOLD && (w_next_idx == LAST_IDX))) ? '0 : w_rd_b;

  tap_ring_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ring (
    .clock     (clock),
    .reset     (reset),
    .i_wr_en   (w_accept),
    .i_wr_data (in_data),
    .i_off_a   (w_off_a),
    .i_off_b   (w_off_b),
    .o_rd_a    (w_rd_a),
    .o_rd_b    (w_rd_b)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_tap_valid <= 1'b0;
      r_start     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
    end else if (clk_enable) begin
      if (w_accept) begin
        r_state     <= STREAM;
        r_tap_valid <= 1'b1;
        r_start     <= 1'b1;
        r_last      <= (LAST_IDX == '0);
        r_busy      <= 1'b1;
        r_idx       <= '0;
        r_a         <= in_data;
        r_b         <= w_b_first;
        r_in_ready  <= (LAST_IDX == '0);
      end else if ((r_state == STREAM) && !r_last) begin
        r_idx       <= w_next_idx;
        r_start     <= 1'b0;
        r_last      <= (w_next_idx == LAST_IDX);
        r_a         <= w_rd_a;
        r_b         <= w_b_stream;
        r_in_ready  <= (w_next_idx == LAST_IDX);
      end else begin
        r_state     <= IDLE;
        r_tap_valid <= 1'b0;
        r_start     <= 1'b0;
        r_last      <= 1'b0;
        r_busy      <= 1'b0;
        r_idx       <= '0;
        r_a         <= '0;
        r_b         <= '0;
        r_in_ready  <= 1'b1;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign tap_valid   = r_tap_valid;
  assign tap_idx     = r_idx;
  assign tap_a       = r_a;
  assign tap_b       = r_b;
  assign frame_start = r_start;
  assign frame_last  = r_last;
  assign busy        = r_busy;

endmodule

// File: tb/tb_tap_stream_ctrl.sv
// Bench for tap_stream_ctrl: DEPTH=5 instances with FOLD=0 and FOLD=1,
// scoreboard of expected taps built from a sample-history model.
module tb_tap_stream_ctrl;

  typedef struct {
    logic [2:0]         idx;
    logic signed [13:0] a;
    logic signed [13:0] b;
    logic               st;
    logic               ls;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic [1:0] in_valid = '0;
  logic signed [13:0] in_data [2];
  logic [1:0] in_ready, tap_valid, fstart, flast, busy;
  logic [2:0] idx0;
  logic [1:0] idx1;
  logic signed [13:0] a0, b0, a1, b1;

  int checks   = 0;
  int failures = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic signed [13:0] hist0 [5];
  logic signed [13:0] hist1 [5];

  always #5 clk = ~clk;

  tap_stream_ctrl #(.DATA_W(14), .DEPTH(5), .FOLD(0)) u_dut0 (
    .clock(clk), .reset(rst), .clk_enable(en),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .tap_valid(tap_valid[0]), .tap_idx(idx0), .tap_a(a0), .tap_b(b0),
    .frame_start(fstart[0]), .frame_last(flast[0]), .busy(busy[0])
  );

  tap_stream_ctrl #(.DATA_W(14), .DEPTH(5), .FOLD(1)) u_dut1 (
    .clock(clk), .reset(rst), .clk_enable(en),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .tap_valid(tap_valid[1]), .tap_idx(idx1), .tap_a(a1), .tap_b(b1),
    .frame_start(fstart[1]), .frame_last(flast[1]), .busy(busy[1])
  );

  task automatic clear_model();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 5; i++) begin
      hist0[i] = '0;
      hist1[i] = '0;
    end
  endtask

  task automatic model_accept(input int d, input logic signed [13:0] v);
    exp_t e;
    if (d == 0) begin
      for (int i = 4; i > 0; i--) hist0[i] = hist0[i-1];
      hist0[0] = v;
      for (int j = 0; j < 5; j++) begin
        e.idx = 3'(j); e.a = hist0[j]; e.b = '0;
        e.st = (j == 0); e.ls = (j == 4);
        q0.push_back(e);
      end
    end else begin
      for (int i = 4; i > 0; i--) hist1[i] = hist1[i-1];
      hist1[0] = v;
      for (int j = 0; j < 3; j++) begin
        e.idx = 3'(j); e.a = hist1[j];
        e.b = (j == 2) ? 14'sd0 : hist1[4-j];
        e.st = (j == 0); e.ls = (j == 2);
        q1.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = '0;
    @(negedge clk);
    clear_model();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input int d, input logic signed [13:0] v);
    @(negedge clk);
    checks++;
    if (in_ready[d] !== 1'b1) begin
      failures++;
      $display("FAIL send_ready dut%0d got=%b exp=1", d, in_ready[d]);
    end
    in_valid[d] = 1'b1;
    in_data[d]  = v;
    model_accept(d, v);
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy[0] && !busy[1] && q0.size() == 0 && q1.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Scoreboard consumer: one expected entry per tap produced on an enabled edge.
  initial begin : monitor
    logic en_s, rst_s;
    exp_t e;
    forever begin
      @(posedge clk);
      en_s  = en;
      rst_s = rst;
      @(negedge clk);
      if (en_s && !rst_s) begin
        if (tap_valid[0]) begin
          checks++;
          if (q0.size() == 0) begin
            failures++;
            $display("FAIL tap0_unexpected idx=%0d a=%0d", idx0, a0);
          end else begin
            e = q0.pop_front();
            if ({idx0, a0, b0, fstart[0], flast[0]} !== {e.idx, e.a, e.b, e.st, e.ls}) begin
              failures++;
              $display("FAIL tap0 got idx=%0d a=%0d b=%0d s=%b l=%b exp idx=%0d a=%0d b=%0d s=%b l=%b",
                       idx0, a0, b0, fstart[0], flast[0], e.idx, e.a, e.b, e.st, e.ls);
            end
          end
        end
        if (tap_valid[1]) begin
          checks++;
          if (q1.size() == 0) begin
            failures++;
            $display("FAIL tap1_unexpected idx=%0d a=%0d", idx1, a1);
          end else begin
            e = q1.pop_front();
            if ({1'b0, idx1, a1, b1, fstart[1], flast[1]} !== {e.idx, e.a, e.b, e.st, e.ls}) begin
              failures++;
              $display("FAIL tap1 got idx=%0d a=%0d b=%0d s=%b l=%b exp idx=%0d a=%0d b=%0d s=%b l=%b",
                       idx1, a1, b1, fstart[1], flast[1], e.idx, e.a, e.b, e.st, e.ls);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = '0;
    @(negedge clk);
    checks++;
    if ({in_ready, tap_valid, busy, fstart, flast} !== 10'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0", {in_ready, tap_valid, busy, fstart, flast});
    end
    checks++;
    if ({idx0, idx1, a0, b0, a1, b1} !== 61'b0) begin
      failures++;
      $display("FAIL reset_data got idx0=%0d a0=%0d b0=%0d a1=%0d b1=%0d exp 0", idx0, a0, b0, a1, b1);
    end
    clear_model();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 2'b11) begin
      failures++;
      $display("FAIL reset_ready_after got=%b exp=11", in_ready);
    end
  endtask

  task automatic test_fold0_basic();
    bit ok;
    do_reset();
    for (int v = 1; v <= 3; v++) begin
      send(0, 14'(v));
      drain(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL fold0_basic_drain sample=%0d left=%0d exp=0", v, q0.size());
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    for (int v = 1; v <= 7; v++) begin
      send(0, 14'(v));
      drain(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL wrap_drain sample=%0d left=%0d exp=0", v, q0.size());
      end
    end
  endtask

  task automatic test_fold1();
    bit ok;
    do_reset();
    for (int v = 10; v <= 50; v += 10) begin
      send(1, 14'(v));
      drain(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL fold1_drain sample=%0d left=%0d exp=0", v, q1.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int starts;
    logic signed [13:0] nxt;
    do_reset();
    starts = 0;
    nxt = 14'sd101;
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 14'sd100;
    model_accept(0, 14'sd100);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if (tap_valid[0] !== 1'b1) begin
        failures++;
        $display("FAIL b2b_valid cycle=%0d got=%b exp=1", i, tap_valid[0]);
      end
      checks++;
      if (in_ready[0] !== ((i % 5) == 0)) begin
        failures++;
        $display("FAIL b2b_ready cycle=%0d got=%b exp=%b", i, in_ready[0], ((i % 5) == 0));
      end
      if (fstart[0]) starts++;
      if (i == 20) in_valid[0] = 1'b0;
      else if (in_ready[0]) begin
        in_data[0] = nxt;
        model_accept(0, nxt);
        nxt = nxt + 14'sd1;
      end
    end
    checks++;
    if (starts != 4) begin
      failures++;
      $display("FAIL b2b_starts got=%0d exp=4", starts);
    end
    drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL b2b_drain left=%0d exp=0", q0.size());
    end
  endtask

  task automatic test_enable_hold();
    bit ok;
    do_reset();
    send(0, 14'sd5);
    drain(ok);
    send(0, 14'sd6);
    drain(ok);
    send(0, 14'sd7);
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    in_valid[1] = 1'b1;
    in_data[1]  = 14'sd77;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({idx0, a0, tap_valid[0], busy[1], tap_valid[1]} !== {3'd2, 14'sd5, 1'b1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL en_hold got idx=%0d a=%0d v=%b busy1=%b v1=%b exp idx=2 a=5 v=1 busy1=0 v1=0",
                 idx0, a0, tap_valid[0], busy[1], tap_valid[1]);
      end
    end
    in_valid[1] = 1'b0;
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (idx0 !== 3'd3) begin
      failures++;
      $display("FAIL en_resume got idx=%0d exp=3", idx0);
    end
    drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL en_drain left0=%0d left1=%0d exp=0", q0.size(), q1.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    send(0, 14'sd4);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (idx0 !== 3'd2) begin
      failures++;
      $display("FAIL rstmid_pre got idx=%0d exp=2", idx0);
    end
    rst = 1'b1;
    @(negedge clk);
    clear_model();
    checks++;
    if ({tap_valid[0], flast[0], busy[0], in_ready[0], fstart[0], idx0, a0, b0} !== 36'b0) begin
      failures++;
      $display("FAIL rstmid_clear got v=%b l=%b busy=%b rdy=%b s=%b idx=%0d a=%0d b=%0d exp all 0",
               tap_valid[0], flast[0], busy[0], in_ready[0], fstart[0], idx0, a0, b0);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_ready got=%b exp=1", in_ready[0]);
    end
    send(0, 14'sd9);
    drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rstmid_drain left=%0d exp=0", q0.size());
    end
  endtask

  initial begin
    in_data[0] = '0;
    in_data[1] = '0;
    clear_model();
    test_reset();
    test_fold0_basic();
    test_wrap();
    test_fold1();
    test_back_to_back();
    test_enable_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached without finishing");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tap_stream_ctrl.md
Name: tap_stream_ctrl

Overview:
Parametrised successor to the filterbank sample-history control. Holds the last DEPTH input samples in a circular register buffer and replaces the shift-all delay line and gated phase clock with a clock-enabled design. Each accepted sample starts one frame: the block streams the tap history serially, one tap or one symmetric tap pair per cycle, to the serial-MAC filter bank. Input uses a valid/ready handshake; frame boundaries are marked with start and last strobes.

Parameters:
DATA_W, 14, sample width in bits (signed).
DEPTH, 119, number of taps kept (≥2).
FOLD, 0, 0 = one tap per cycle; 1 = symmetric pair per cycle.
NCYC, derived, cycles per frame: DEPTH when FOLD=0, ceil(DEPTH/2) when FOLD=1. Not user-overridable.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
clk_enable  in  1  global advance enable; low freezes all state and outputs
in_valid  in  1  sample offered
in_ready  out  1  block can accept a sample this cycle
in_data  in  DATA_W  signed input sample
tap_valid  out  1  tap outputs valid this cycle
tap_idx  out  $clog2(NCYC) (min 1)  position within the frame, 0..NCYC-1
tap_a  out  DATA_W  x[n-idx]
tap_b  out  DATA_W  x[n-(DEPTH-1-idx)] when FOLD=1, else 0
frame_start  out  1  high with idx 0
frame_last  out  1  high with idx NCYC-1
busy  out  1  frame in progress

Behaviour:
- Reset (synchronous, active-high; overrides clk_enable): write pointer 0; all buffer entries 0; state IDLE; tap_valid, frame_start, frame_last, busy, tap_idx, tap_a, tap_b all 0; in_ready 0 in the reset cycle and 1 from the first cycle after reset.
- States:
  - IDLE: in_ready=1.
  - STREAM: in_ready=frame_last.
- An accept is in_valid & in_ready & clk_enable at a rising edge.
  - The sample is written at the write pointer, which then increments modulo DEPTH.
  - Any state goes to STREAM.
- Latency: the first tap appears one cycle after the accept edge, with tap_valid=1, tap_idx=0 and frame_start=1. tap_a at idx 0 is the sample just accepted.
- Within STREAM, tap_idx increments by 1 per enabled cycle. frame_last=1 at idx NCYC-1.
- After the last tap:
  - If an accept occurred on the last cycle, the next cycle is idx 0 of the new frame, with no bubble. The sustained rate is one sample per NCYC cycles.
  - Otherwise the state returns to IDLE and tap_valid=0.
- Frame snapshot: a frame sees exactly the DEPTH most recent accepted samples, including its own. Slots never written since reset read 0.
- FOLD=1 with odd DEPTH: the final idx is the centre tap. tap_a=x[n-(DEPTH-1)/2] and tap_b=0, so the centre is not double-counted.
- FOLD=0: tap_b is always 0.
- clk_enable=0: no state, pointer, buffer or output register changes; outputs hold. An offered sample is not accepted.
- Reset mid-frame: the frame is aborted; frame_last is never issued; the buffer is cleared.
- in_valid is ignored while in_ready=0. The source must hold in_data stable until accepted.
- All outputs are registered; there is no combinational path from in_valid to in_ready.
- Arithmetic: address = (wr_ptr_of_newest − offset) mod DEPTH, computed without a divider (conditional add of DEPTH). Pointer width is $clog2(DEPTH).

Decomposition:
- Package tap_stream_pkg holds:
  - the function ncyc(DEPTH, FOLD);
  - the function for the safe clog2 (min 1);
  - a state enum {IDLE, STREAM}.
- One sub-module, tap_ring_buf: DEPTH×DATA_W register ring with one write port (write pointer internal), two asynchronous read ports addressed by offset-from-newest, and synchronous clear on reset.

Test Plan:
1. DEPTH=5, FOLD=0: reset, then accept 1, 2, 3 spaced apart -> third frame tap_a = 3,2,1,0,0 with idx 0..4; frame_start on idx 0; frame_last on idx 4; tap_b=0.
2. DEPTH=5, FOLD=0: accept 1..7 -> last frame tap_a = 7,6,5,4,3, proving pointer wrap-around.
3. DEPTH=5, FOLD=1: accept 10, 20, 30, 40, 50 -> final frame (a,b) = (50,10), (40,20), (30,0); NCYC=3; frame_last at idx 2.
4. in_valid held high continuously with DEPTH=5, FOLD=0 -> an accept every 5 cycles, frame_start every 5th cycle, tap_valid never drops between frames.
5. clk_enable low for 3 cycles at idx 2 -> outputs hold idx 2 values for those cycles; the frame then resumes at idx 3; no accept occurs while clk_enable is low.
6. Reset asserted at idx 2 -> next cycle all outputs 0 and in_ready 0; then in_ready=1; a new accept of 9 yields tap_a = 9,0,0,0,0.
